// File: rtl/warp_switch_scheduler.sv
// ---------------------------------------------------------------------------
// warp_switch_scheduler
//
// Decides which of two warps owns the shared core pipeline. Ownership rotates
// at instruction boundaries (core_state == UPDATE) once the time quantum has
// expired, or immediately when the active warp finishes. Every rotation
// freezes the core for SWITCH_PENALTY cycles so the per-warp context can be
// swapped.
//
// Optional feature (macro WARP_SWITCH_ON_WAIT_EN): when defined, an active
// warp sitting in WAIT (memory outstanding) hands the core to the other
// eligible warp at once, regardless of the quantum counter.
//
// Parameters
//   QUANTUM         max RUN cycles before rotation is requested (>=1)
//   SWITCH_PENALTY  hold-bubble cycles per switch (>=1)
//
// Ports
//   clk             clock
//   reset           synchronous active-high reset
//   start_1/2       warp has a block assigned
//   done_1/2        warp finished
//   core_state      shared core state (110 = UPDATE boundary, 100 = WAIT)
//   warp_select     0 = warp 1 active, 1 = warp 2 active
//   core_hold       freeze shared core during the switch bubble
//   switch_pulse    one-cycle pulse on the first bubble cycle
//   all_done        every started warp done
//   switch_count    completed switches (wraps at 256)
// ---------------------------------------------------------------------------
module warp_switch_scheduler #(
    parameter int unsigned QUANTUM        = 16,
    parameter int unsigned SWITCH_PENALTY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_1,
    input  logic       start_2,
    input  logic       done_1,
    input  logic       done_2,
    input  logic [2:0] core_state,
    output logic       warp_select,
    output logic       core_hold,
    output logic       switch_pulse,
    output logic       all_done,
    output logic [7:0] switch_count
);

    localparam int unsigned QW = $clog2(QUANTUM + 1);
    localparam int unsigned PW = $clog2(SWITCH_PENALTY + 1);

    localparam logic [QW-1:0] QCNT_MAX  = QW'(QUANTUM);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SWITCH_PENALTY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SWITCH,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [QW-1:0]   qcnt, qcnt_nxt;
    logic [PW-1:0]   pcnt, pcnt_nxt;
    logic            ws_nxt, hold_nxt, pulse_nxt, all_done_nxt;
    logic [7:0]      count_nxt;

    logic elig_1, elig_2, active_done, other_elig, boundary, qexp, wait_hit;

    assign elig_1      = start_1 & ~done_1;
    assign elig_2      = start_2 & ~done_2;
    assign active_done = warp_select ? done_2 : done_1;
    assign other_elig  = warp_select ? elig_1 : elig_2;
    assign boundary    = (core_state == 3'b110);
    assign qexp        = (qcnt == QCNT_MAX);

`ifdef WARP_SWITCH_ON_WAIT_EN
    // Hide memory latency: give the core away while the active warp waits.
    assign wait_hit = (core_state == 3'b100) & other_elig;
`else
    assign wait_hit = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_nxt    = state;
        ws_nxt       = warp_select;
        hold_nxt     = core_hold;
        pulse_nxt    = 1'b0;
        all_done_nxt = all_done;
        count_nxt    = switch_count;
        qcnt_nxt     = qcnt;
        pcnt_nxt     = pcnt;

        case (state)
            // IDLE and DONE share the pick-up rule: warp 1 has first claim.
            // Entering RUN from here is not a switch (no bubble, no pulse).
            ST_IDLE, ST_DONE: begin
                hold_nxt = 1'b0;
                if (elig_1 | elig_2) begin
                    state_nxt    = ST_RUN;
                    ws_nxt       = ~elig_1;
                    all_done_nxt = 1'b0;
                    qcnt_nxt     = '0;
                end
            end

            ST_RUN: begin
                if (active_done) begin
                    if (other_elig) begin
                        state_nxt = ST_SWITCH;
                        ws_nxt    = ~warp_select;
                        hold_nxt  = 1'b1;
                        pulse_nxt = 1'b1;
                        pcnt_nxt  = '0;
                    end else begin
                        state_nxt    = ST_DONE;
                        all_done_nxt = 1'b1;
                    end
                end else if (wait_hit || (boundary && qexp && other_elig)) begin
                    state_nxt = ST_SWITCH;
                    ws_nxt    = ~warp_select;
                    hold_nxt  = 1'b1;
                    pulse_nxt = 1'b1;
                    pcnt_nxt  = '0;
                end else if (!qexp) begin
                    // Saturates at QUANTUM so an expired quantum with no
                    // other taker is re-checked at every later boundary.
                    qcnt_nxt = qcnt + 1'b1;
                end
            end

            ST_SWITCH: begin
                if (pcnt == PCNT_LAST) begin
                    state_nxt = ST_RUN;
                    hold_nxt  = 1'b0;
                    count_nxt = switch_count + 8'd1;
                    qcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            warp_select  <= 1'b0;
            core_hold    <= 1'b0;
            switch_pulse <= 1'b0;
            all_done     <= 1'b0;
            switch_count <= 8'd0;
            qcnt         <= '0;
            pcnt         <= '0;
        end else begin
            state        <= state_nxt;
            warp_select  <= ws_nxt;
            core_hold    <= hold_nxt;
            switch_pulse <= pulse_nxt;
            all_done     <= all_done_nxt;
            switch_count <= count_nxt;
            qcnt         <= qcnt_nxt;
            pcnt         <= pcnt_nxt;
        end
    end

endmodule

// File: tb/tb_warp_switch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_warp_switch_scheduler
//
// Two instances share one stimulus stream: dut_a (QUANTUM=4, SWITCH_PENALTY=1)
// and dut_b (QUANTUM=4, SWITCH_PENALTY=2). Stimulus pushes hand-computed
// expected outputs (tagged with the instance and the cycle they are due) into
// a scoreboard; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_warp_switch_scheduler;

    logic       clk = 1'b0;
    logic       reset, start_1, start_2, done_1, done_2;
    logic [2:0] core_state;

    logic       a_ws, a_hold, a_pulse, a_ad;
    logic [7:0] a_cnt;
    logic       b_ws, b_hold, b_pulse, b_ad;
    logic [7:0] b_cnt;

    warp_switch_scheduler #(.QUANTUM(4), .SWITCH_PENALTY(1)) dut_a (
        .clk(clk), .reset(reset), .start_1(start_1), .start_2(start_2),
        .done_1(done_1), .done_2(done_2), .core_state(core_state),
        .warp_select(a_ws), .core_hold(a_hold), .switch_pulse(a_pulse),
        .all_done(a_ad), .switch_count(a_cnt)
    );

    warp_switch_scheduler #(.QUANTUM(4), .SWITCH_PENALTY(2)) dut_b (
        .clk(clk), .reset(reset), .start_1(start_1), .start_2(start_2),
        .done_1(done_1), .done_2(done_2), .core_state(core_state),
        .warp_select(b_ws), .core_hold(b_hold), .switch_pulse(b_pulse),
        .all_done(b_ad), .switch_count(b_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: parallel queues, one entry per expected observation.
    int          q_due[$];
    bit          q_sel[$];
    logic [11:0] q_exp[$];
    string       q_name[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] mon_got, mon_exp;
    bit          mon_sel;
    string       mon_name;

    always @(negedge clk) begin
        while (q_due.size() > 0 && q_due[0] <= cyc) begin
            void'(q_due.pop_front());
            mon_sel  = q_sel.pop_front();
            mon_exp  = q_exp.pop_front();
            mon_name = q_name.pop_front();
            mon_got  = mon_sel ? {b_ws, b_hold, b_pulse, b_ad, b_cnt}
                               : {a_ws, a_hold, a_pulse, a_ad, a_cnt};
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_bad++;
                $display("FAIL %s (dut_%s): got ws=%b hold=%b pulse=%b all_done=%b cnt=%0d, want ws=%b hold=%b pulse=%b all_done=%b cnt=%0d",
                         mon_name, mon_sel ? "b" : "a",
                         mon_got[11], mon_got[10], mon_got[9], mon_got[8], mon_got[7:0],
                         mon_exp[11], mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
            end
        end
    end

    task automatic drive(input logic rst, input logic s1, input logic s2,
                         input logic d1, input logic d2, input logic [2:0] cs);
        reset      = rst;
        start_1    = s1;
        start_2    = s2;
        done_1     = d1;
        done_2     = d2;
        core_state = cs;
    endtask

    // Expected outputs after the next rising edge.
    task automatic push(input bit sel, input logic ws, input logic hold,
                        input logic pulse, input logic ad, input logic [7:0] cnt,
                        input string nm);
        q_due.push_back(cyc + 1);
        q_sel.push_back(sel);
        q_exp.push_back({ws, hold, pulse, ad, cnt});
        q_name.push_back(nm);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m, r;

        // ---------------- reset state ----------------
        drive(1, 0, 0, 0, 0, 3'b000);
        tick;
        tick;
        push(0, 0, 0, 0, 0, 8'd0, "reset_a");
        push(1, 0, 0, 0, 0, 8'd0, "reset_b");
        tick;

        // ---------------- reset mid-SWITCH (dut_b, penalty 2) ----------------
        drive(0, 1, 1, 0, 0, 3'b000);
        push(1, 0, 0, 0, 0, 8'd0, "mid_run");
        tick;
        drive(0, 1, 1, 1, 0, 3'b000);
        push(1, 1, 1, 1, 0, 8'd0, "mid_bubble1");
        tick;
        drive(0, 1, 1, 0, 0, 3'b000);
        push(1, 1, 1, 0, 0, 8'd0, "mid_bubble2");
        tick;
        drive(1, 1, 1, 0, 0, 3'b000);
        push(1, 0, 0, 0, 0, 8'd0, "mid_reset_b");
        push(0, 0, 0, 0, 0, 8'd0, "mid_reset_a");
        tick;
        tick;

        // ---------------- round robin (dut_a) ----------------
        // Boundary every 3rd cycle; first switch at k=5 (qcnt reaches 4),
        // then a 6-cycle rhythm: 1 bubble cycle + 5 run cycles.
        for (int k = 0; k <= 18; k++) begin
            drive(0, 1, 1, 0, 0, (k % 3 == 2) ? 3'b110 : 3'b000);
            if (k < 5) begin
                push(0, 0, 0, 0, 0, 8'd0, "rr_first");
            end else begin
                m = (k - 5) / 6;
                r = (k - 5) % 6;
                push(0, (m % 2 == 0), (r == 0), (r == 0), 0,
                     8'(m + ((r == 0) ? 0 : 1)), "rr");
            end
            tick;
        end

        // ---------------- single warp + late start (dut_a) ----------------
        drive(1, 0, 0, 0, 0, 3'b000);
        push(0, 0, 0, 0, 0, 8'd0, "reset_a2");
        tick;
        for (int k = 0; k <= 12; k++) begin
            drive(0, 1, 0, 0, 0, (k % 3 == 2) ? 3'b110 : 3'b000);
            push(0, 0, 0, 0, 0, 8'd0, "single_run");
            tick;
        end
        drive(0, 1, 0, 1, 0, 3'b000);
        push(0, 0, 0, 0, 1, 8'd0, "single_done");
        tick;
        push(0, 0, 0, 0, 1, 8'd0, "done_hold");
        tick;
        drive(0, 1, 1, 1, 0, 3'b000);
        push(0, 1, 0, 0, 0, 8'd0, "late_start");
        tick;
        push(0, 1, 0, 0, 0, 8'd0, "late_run");
        tick;

        // ---------------- early finish (dut_a) ----------------
        drive(1, 0, 0, 0, 0, 3'b000);
        push(0, 0, 0, 0, 0, 8'd0, "reset_a3");
        tick;
        drive(0, 1, 1, 0, 0, 3'b000);
        push(0, 0, 0, 0, 0, 8'd0, "ef_run");
        tick;
        drive(0, 1, 1, 0, 0, 3'b001);
        push(0, 0, 0, 0, 0, 8'd0, "ef_run_b");
        tick;
        drive(0, 1, 1, 1, 0, 3'b010);
        push(0, 1, 1, 1, 0, 8'd0, "ef_switch");
        tick;
        drive(0, 1, 1, 1, 0, 3'b011);
        push(0, 1, 0, 0, 0, 8'd1, "ef_run2");
        tick;
        drive(0, 1, 1, 1, 1, 3'b011);
        push(0, 1, 0, 0, 1, 8'd1, "ef_all_done");
        tick;

        // ---------------- WAIT handling (dut_a) ----------------
        drive(1, 0, 0, 0, 0, 3'b000);
        push(0, 0, 0, 0, 0, 8'd0, "reset_a4");
        tick;
        drive(0, 1, 1, 0, 0, 3'b000);
        push(0, 0, 0, 0, 0, 8'd0, "wait_run0");
        tick;
        push(0, 0, 0, 0, 0, 8'd0, "wait_run1");
        tick;
        drive(0, 1, 1, 0, 0, 3'b100);
`ifdef WARP_SWITCH_ON_WAIT_EN
        push(0, 1, 1, 1, 0, 8'd0, "wait_switch");
        tick;
        push(0, 1, 0, 0, 0, 8'd1, "wait_run2");
        tick;
        push(0, 0, 1, 1, 0, 8'd1, "wait_switch2");
        tick;
        drive(0, 1, 1, 0, 0, 3'b110);
        push(0, 0, 0, 0, 0, 8'd2, "wait_run3");
        tick;
`else
        push(0, 0, 0, 0, 0, 8'd0, "wait_noswitch1");
        tick;
        push(0, 0, 0, 0, 0, 8'd0, "wait_noswitch2");
        tick;
        push(0, 0, 0, 0, 0, 8'd0, "wait_noswitch3");
        tick;
        drive(0, 1, 1, 0, 0, 3'b110);
        push(0, 1, 1, 1, 0, 8'd0, "wait_boundary_switch");
        tick;
`endif

        // ---------------- drain ----------------
        drive(0, 0, 0, 0, 0, 3'b000);
        tick;
        tick;
        for (int i = 0; i < 20 && q_due.size() > 0; i++) tick;
        if (q_due.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", q_due.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/warp_switch_scheduler.md
Name: warp_switch_scheduler

Overview:
- Decides which of two warps owns the shared core pipeline. Drives warp_select into the per-warp state mux/capture block.
- Rotates ownership at instruction boundaries when the time quantum expires or the active warp finishes.
- Inserts a hold bubble while per-warp context swaps.
- Reports aggregate completion and a switch counter.

Parameters:
QUANTUM, 16, max cycles a warp owns the core before rotation is requested (>=1)
SWITCH_PENALTY, 1, hold-bubble cycles per switch (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_1  in  1  warp 1 has a block assigned
start_2  in  1  warp 2 has a block assigned
done_1  in  1  warp 1 finished
done_2  in  1  warp 2 finished
core_state  in  3  shared core state (000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE)
warp_select  out  1  0 = warp 1 active, 1 = warp 2 active
core_hold  out  1  freeze shared core (switch bubble)
switch_pulse  out  1  one-cycle pulse on the first bubble cycle
all_done  out  1  every started warp done
switch_count  out  8  number of completed switches

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous active-high on port reset and takes priority over all other inputs, including mid-switch.
- Reset values: warp_select=0, core_hold=0, switch_pulse=0, all_done=0, switch_count=0, state=IDLE, qcnt=0, pcnt=0.
- Eligibility: elig_k = start_k & ~done_k. Active warp = warp selected by warp_select.
- Boundary: boundary = (core_state==110).
- Quantum expiry: qexp = (qcnt==QUANTUM).
- qcnt width: $clog2(QUANTUM+1). Increments each RUN cycle and saturates at QUANTUM. Cleared on entry to RUN.
- FSM states: IDLE, RUN, SWITCH, DONE.
- IDLE:
  - elig_1 -> RUN, warp_select=0.
  - Else elig_2 -> RUN, warp_select=1.
  - Else stay.
  - Entry into RUN from IDLE is not a switch: no pulse, no bubble.
- RUN, evaluated every cycle in this priority:
  1. Active done_k=1 and other warp eligible -> SWITCH (any cycle, not only at boundary).
  2. Active done and other warp ineligible -> DONE.
  3. boundary & qexp & other warp eligible -> SWITCH.
  4. boundary & qexp & other ineligible -> stay; qcnt holds at QUANTUM and is re-checked at each boundary.
  5. Otherwise stay.
- SWITCH:
  - On entry: warp_select toggles, core_hold=1, switch_pulse=1 for the first cycle only, pcnt=0.
  - Lasts exactly SWITCH_PENALTY cycles with core_hold=1.
  - On the last cycle: switch_count increments (wraps 255->0), then -> RUN with qcnt=0.
  - done/start changes during SWITCH are ignored until RUN.
- DONE:
  - all_done=1 and core_hold=0; warp_select holds.
  - If any warp becomes eligible (late start) -> RUN with the same rule as IDLE; all_done clears on the same edge.
- Output timing: all outputs are registered and change on the edge after the deciding inputs.
- Same-cycle boundary and active done: rule 1/2 (done) takes precedence.

Optional Feature:
- Macro: WARP_SWITCH_ON_WAIT_EN.
- Defined: in RUN, core_state==100 (WAIT, memory outstanding) with other warp eligible -> SWITCH immediately, regardless of qcnt. Priority below rules 1/2, above rule 3. Latency hiding.
- Undefined: WAIT is treated like any non-boundary state; switches occur only per rules 1-3.

Test Plan:
- Reset mid-SWITCH (QUANTUM=4, SWITCH_PENALTY=2): assert reset during the second bubble cycle -> next cycle warp_select=0, core_hold=0, switch_count=0, state IDLE.
- Round robin (QUANTUM=4, SWITCH_PENALTY=1): start_1=start_2=1, core_state pulses 110 every 3 cycles -> first switch at the first boundary with qcnt==4; warp_select 0->1 with a 1-cycle core_hold/switch_pulse; repeats alternately; switch_count increments by 1 per switch.
- Single warp: start_1=1 only, boundaries continuing -> warp_select stays 0, no core_hold ever; done_1=1 -> all_done=1 next cycle.
- Early finish: both started, warp 1 active, done_1 asserted on a non-boundary cycle -> switch to warp 2 next cycle; then done_2 -> all_done=1, switch_count=1.
- Late start: only start_1, run to DONE (all_done=1); then assert start_2 -> RUN with warp_select=1, all_done=0, no switch_pulse, switch_count unchanged.
- WARP_SWITCH_ON_WAIT_EN defined, both started, core_state=100 at qcnt=1 -> SWITCH next cycle. With the macro undefined, the same stimulus gives no switch until the first boundary with qcnt==QUANTUM.
